// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for R10K-style renaming.
// A speculative head feeds dispatch; an architectural head lets a mispredict reclaim in-flight tags.
module free_list #(
    parameter int PREG_NUMBER = 64,
    parameter int AREG_NUMBER = 32,
    parameter bit DEBUG = 1'b1,
    localparam int TW = $clog2(PREG_NUMBER),
    localparam int FL_SIZE = PREG_NUMBER - AREG_NUMBER,
    localparam int PW = $clog2(FL_SIZE) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dispatch_en_i,
    input  logic                dispatch_size_i,
    input  logic [1:0]          retire_en_i,
    input  logic [1:0][TW-1:0]  T_old_i,
    input  logic                branch_mispredicted_i,
    output logic [1:0][TW-1:0]  freeReg_o,
    output logic [1:0]          free_status_o,
    output logic [PW-1:0]       head_debug,
    output logic [PW-1:0]       head_arch_debug,
    output logic [PW-1:0]       tail_debug,
    output logic [PW-1:0]       count_debug
);
    localparam int IW = PW - 1;

    logic [TW-1:0] entries [FL_SIZE];
    logic [PW-1:0] head_spec, head_arch, tail, count, n, head_spec_next;
    logic [IW-1:0] hs_idx1, wr_idx1;
    logic          grant;

    assign count = tail - head_spec;
    assign n = PW'(retire_en_i[0]) + PW'(retire_en_i[1]);
    // Availability uses the pre-update count: tags retired this cycle are not yet allocatable.
    assign grant = dispatch_en_i && !branch_mispredicted_i &&
                   (dispatch_size_i ? count >= PW'(2) : count != '0);
    assign head_spec_next = branch_mispredicted_i ? head_arch + n :
                            head_spec + (grant ? (dispatch_size_i ? PW'(2) : PW'(1)) : PW'(0));
    assign hs_idx1 = head_spec[IW-1:0] + IW'(1);
    assign wr_idx1 = tail[IW-1:0] + IW'(retire_en_i[0]);

    assign freeReg_o[0] = entries[head_spec[IW-1:0]];
    assign freeReg_o[1] = entries[hs_idx1];
    assign free_status_o = count == '0 ? 2'b00 : count == PW'(1) ? 2'b01 : 2'b10;

    assign head_debug      = DEBUG ? head_spec : '0;
    assign head_arch_debug = DEBUG ? head_arch : '0;
    assign tail_debug      = DEBUG ? tail : '0;
    assign count_debug     = DEBUG ? count : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) entries[i] <= TW'(AREG_NUMBER + i);
            head_spec <= '0;
            head_arch <= '0;
            tail      <= PW'(FL_SIZE);
        end else begin
            if (retire_en_i[0]) entries[tail[IW-1:0]] <= T_old_i[0];
            if (retire_en_i[1]) entries[wr_idx1] <= T_old_i[1];
            head_spec <= head_spec_next;
            head_arch <= head_arch + n;
            tail      <= tail + n;
        end
    end

    if (DEBUG) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (reset)
            32'(count) + 32'(n) <= 32'(FL_SIZE));
    end
endmodule
